// File: rtl/floating_point_to_integer.sv
// IEEE-754 single-precision to signed integer converter, truncating toward zero.
// Uses an iterative one-bit-per-cycle shifter behind valid/ready handshakes on both sides.
module floating_point_to_integer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int INT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] floating_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [INT_WIDTH-1:0]  integer_out,
  output logic                  overflow_out,
  output logic                  invalid_out
);

  localparam int SIG_W = MENT_WIDTH + 1;
  localparam int CNT_W = 5;
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX    = '1;
  localparam logic [EXPO_WIDTH-1:0] EXP_BIAS   = EXPO_WIDTH'((1 << (EXPO_WIDTH - 1)) - 1);
  localparam logic [EXPO_WIDTH-1:0] EXP_SHIFT0 = EXP_BIAS + EXPO_WIDTH'(MENT_WIDTH);
  localparam logic [EXPO_WIDTH-1:0] EXP_SAT    = EXP_BIAS + EXPO_WIDTH'(INT_WIDTH - 1);
  localparam logic [INT_WIDTH-1:0]  INT_MIN    = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [INT_WIDTH-1:0]  INT_MAX    = {1'b0, {(INT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;

  state_t                r_state;
  logic [INT_WIDTH-1:0]  r_work;
  logic [CNT_W-1:0]      r_count;
  logic                  r_left;
  logic                  r_sign;
  logic [INT_WIDTH-1:0]  r_int;
  logic                  r_ovf;
  logic                  r_inv;
  logic                  r_ready_out;
  logic                  r_valid_out;

  logic                  w_sign;
  logic [EXPO_WIDTH-1:0] w_expo;
  logic [MENT_WIDTH-1:0] w_ment;
  logic [SIG_W-1:0]      w_sig;
  logic                  w_left;
  logic [CNT_W-1:0]      w_count;
  logic                  w_special;
  logic [INT_WIDTH-1:0]  w_spec_int;
  logic                  w_spec_ovf;
  logic                  w_spec_inv;

  assign w_sign  = floating_in[DATA_WIDTH-1];
  assign w_expo  = floating_in[DATA_WIDTH-2 -: EXPO_WIDTH];
  assign w_ment  = floating_in[MENT_WIDTH-1:0];
  assign w_sig   = {|w_expo, w_ment};
  assign w_left  = (w_expo >= EXP_SHIFT0);
  assign w_count = w_left ? CNT_W'(w_expo - EXP_SHIFT0) : CNT_W'(EXP_SHIFT0 - w_expo);

  // Special-case classification in priority order; anything left takes the shifter.
  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_special  = 1'b1;
    w_spec_int = '0;
    w_spec_ovf = 1'b0;
    w_spec_inv = 1'b0;
    if (w_expo == EXP_MAX && w_ment != '0) begin
      w_spec_inv = 1'b1;
    end else if (w_expo == EXP_MAX) begin
      w_spec_int = w_sign ? INT_MIN : INT_MAX;
      w_spec_ovf = 1'b1;
    end else if (w_expo < EXP_BIAS) begin
      w_spec_int = '0;
    end else if (w_expo == EXP_SAT && w_sign && w_ment == '0) begin
      w_spec_int = INT_MIN;
    end else if (w_expo >= EXP_SAT) begin
      w_spec_int = w_sign ? INT_MIN : INT_MAX;
      w_spec_ovf = 1'b1;
    end else begin
      w_special = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_count     <= '0;
      r_left      <= 1'b0;
      r_sign      <= 1'b0;
      r_int       <= '0;
      r_ovf       <= 1'b0;
      r_inv       <= 1'b0;
      r_ready_out <= 1'b1;
      r_valid_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_sign      <= w_sign;
            r_left      <= w_left;
            r_work      <= {{(INT_WIDTH-SIG_W){1'b0}}, w_sig};
            r_count     <= w_count;
            r_ready_out <= 1'b0;
            if (w_special) begin
              r_int       <= w_spec_int;
              r_ovf       <= w_spec_ovf;
              r_inv       <= w_spec_inv;
              r_valid_out <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_ovf   <= 1'b0;
              r_inv   <= 1'b0;
              r_state <= (w_count == '0) ? SIGN : SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work  <= r_left ? (r_work << 1) : (r_work >> 1);
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) r_state <= SIGN;
        end
        SIGN: begin
          r_int       <= r_sign ? -r_work : r_work;
          r_valid_out <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (ready_in) begin
            r_valid_out <= 1'b0;
            r_ready_out <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_out    = r_ready_out;
  assign valid_out    = r_valid_out;
  assign integer_out  = r_int;
  assign overflow_out = r_ovf;
  assign invalid_out  = r_inv;

endmodule

// File: tb/tb_floating_point_to_integer.sv
// Scoreboard bench for floating_point_to_integer: directed vectors push expectations,
// a negedge monitor pops and compares each result as valid_out rises.
module tb_floating_point_to_integer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] floating_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] integer_out;
  logic        overflow_out;
  logic        invalid_out;

  floating_point_to_integer dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .floating_in  (floating_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .integer_out  (integer_out),
    .overflow_out (overflow_out),
    .invalid_out  (invalid_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] val;
    logic        ovf;
    logic        inv;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   prev_v = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on the first DONE cycle, then require outputs to hold while stalled.
  always @(negedge clk_in) begin
    if (valid_out && !prev_v) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%08h with no conversion pending (cycle %0d)",
                 integer_out, cyc);
      end else begin
        cur = q.pop_front();
        check("integer_out", integer_out, cur.val);
        check("overflow_out", {31'b0, overflow_out}, {31'b0, cur.ovf});
        check("invalid_out", {31'b0, invalid_out}, {31'b0, cur.inv});
        check("latency", cyc - cur.acc + 1, cur.lat);
      end
      check("ready_out_in_done", {31'b0, ready_out}, 32'd0);
    end else if (valid_out) begin
      check("hold_integer_out", integer_out, cur.val);
      check("hold_flags", {30'b0, overflow_out, invalid_out}, {30'b0, cur.ovf, cur.inv});
      check("hold_ready_out", {31'b0, ready_out}, 32'd0);
    end
    prev_v = valid_out;
  end

  task automatic send(input logic [31:0] f, input logic [31:0] e_val,
                      input logic e_ovf, input logic e_inv, input int e_lat);
    exp_t e;
    int   t = 0;
    while (!ready_out && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    if (!ready_out) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: ready_out stayed 0 for input 0x%08h", f);
      return;
    end
    e.val = e_val;
    e.ovf = e_ovf;
    e.inv = e_inv;
    e.lat = e_lat;
    e.acc = cyc + 1;
    q.push_back(e);
    valid_in    = 1'b1;
    floating_in = f;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    int t;
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    ready_in    = 1'b1;
    floating_in = '0;
    idle(3);
    check("reset_ready_out", {31'b0, ready_out}, 32'd1);
    check("reset_valid_out", {31'b0, valid_out}, 32'd0);
    check("reset_integer_out", integer_out, 32'd0);
    check("reset_flags", {30'b0, overflow_out, invalid_out}, 32'd0);
    rst_in = 1'b0;
    idle(1);

    // Normal path: latency = shift count + 2.
    send(32'h40700000, 32'h00000003, 1'b0, 1'b0, 24);  // 3.75
    send(32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0, 25);  // -1.0
    send(32'h4E800000, 32'h40000000, 1'b0, 1'b0, 9);   // 2^30
    send(32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2);   // 2^23
    send(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9);   // largest float below 2^31
    send(32'hC2F78000, 32'hFFFFFF85, 1'b0, 1'b0, 19);  // -123.75
    // Special cases: one-cycle latency.
    send(32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1);   // -2^31 exact
    send(32'hCF000001, 32'h80000000, 1'b1, 1'b0, 1);   // just below -2^31
    send(32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);   // 2^31
    send(32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 1);   // +inf
    send(32'hFF800000, 32'h80000000, 1'b1, 1'b0, 1);   // -inf
    send(32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1);   // NaN
    send(32'h3F000000, 32'h00000000, 1'b0, 1'b0, 1);   // 0.5
    send(32'h80000000, 32'h00000000, 1'b0, 1'b0, 1);   // -0
    send(32'h00000001, 32'h00000000, 1'b0, 1'b0, 1);   // denormal

    // Backpressure: hold DONE, toggle valid_in with junk data; nothing may be accepted.
    idle(2);
    ready_in = 1'b0;
    send(32'h7FC00000, 32'h00000000, 1'b0, 1'b1, 1);
    t = 0;
    while (!valid_out && t < 50) begin
      @(negedge clk_in);
      t++;
    end
    check("bp_valid_out", {31'b0, valid_out}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      valid_in    = ~valid_in;
      floating_in = $urandom;
      check("bp_no_accept", {31'b0, ready_out}, 32'd0);
      @(negedge clk_in);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(negedge clk_in);
    check("bp_release_ready_out", {31'b0, ready_out}, 32'd1);
    check("bp_release_valid_out", {31'b0, valid_out}, 32'd0);

    // Reset mid-SHIFT: the in-flight -1.0 must vanish without a valid_out pulse.
    valid_in    = 1'b1;
    floating_in = 32'hBF800000;
    @(negedge clk_in);
    valid_in = 1'b0;
    idle(5);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_mid_ready_out", {31'b0, ready_out}, 32'd1);
    check("rst_mid_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_mid_integer_out", integer_out, 32'd0);
    idle(30);
    send(32'h40700000, 32'h00000003, 1'b0, 1'b0, 24);

    // Reset and valid_in together: reset wins, nothing is converted.
    idle(30);
    rst_in      = 1'b1;
    valid_in    = 1'b1;
    floating_in = 32'h4B000000;
    @(negedge clk_in);
    rst_in   = 1'b0;
    valid_in = 1'b0;
    check("rst_wins_ready_out", {31'b0, ready_out}, 32'd1);
    idle(10);
    check("rst_wins_valid_out", {31'b0, valid_out}, 32'd0);

    t = 0;
    while ((q.size() != 0 || valid_out) && t < 200) begin
      @(negedge clk_in);
      t++;
    end
    check("drain_pending", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
